// File: rtl/rbz_spi_frame_tx.sv
// rbz_spi_frame_tx: SPI mode-0 frame transmitter, MSB-first, all outputs registered
module rbz_spi_frame_tx #(
    parameter int MAX_BITS   = 96,
    parameter int LEN_W      = 7,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [LEN_W-1:0]    i_len,
    input  logic [MAX_BITS-1:0] i_data,
    output logic                o_csb,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);
    localparam int CMAX = CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES;
    localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAPN = CW'(GAP_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] bits, bits_n;
    logic [MAX_BITS-1:0] sr, sr_n;
    logic done_n, err_n, len_ok, active_n;
    assign len_ok = i_len != '0 && i_len <= LEN_W'(MAX_BITS);
    assign active_n = state_n == SETUP || state_n == SHIFT_HI || state_n == SHIFT_LO;
    // Payload is left-aligned so the next bit to send is always the MSB
    always_comb begin
        state_n = state;
        cnt_n = cnt - CW'(1);
        bits_n = bits;
        sr_n = sr;
        done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = HALF;
                if (i_start && len_ok) begin
                    state_n = SETUP;
                    bits_n = i_len;
                    sr_n = i_data << (LEN_W'(MAX_BITS) - i_len);
                end else if (i_start) begin
                    err_n = 1'b1;
                end
            end
            SETUP: if (cnt == '0) begin
                state_n = SHIFT_HI;
                cnt_n = HALF;
            end
            SHIFT_HI: if (cnt == '0) begin
                state_n = SHIFT_LO;
                cnt_n = HALF;
                bits_n = bits - LEN_W'(1);
                sr_n = sr << 1;
            end
            SHIFT_LO: if (cnt == '0) begin
                cnt_n = HALF;
                if (bits != '0) begin
                    state_n = SHIFT_HI;
                end else if (GAP_CYCLES == 0) begin
                    state_n = IDLE;
                    done_n = 1'b1;
                end else begin
                    state_n = GAP;
                    cnt_n = GAPN;
                end
            end
            GAP: if (cnt == '0) begin
                state_n = IDLE;
                done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt <= '0;
            bits <= '0;
            sr <= '0;
            o_csb <= 1'b1;
            o_sclk <= 1'b0;
            o_mosi <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bits <= bits_n;
            sr <= sr_n;
            o_csb <= !active_n;
            o_sclk <= state_n == SHIFT_HI;
            o_mosi <= active_n && sr_n[MAX_BITS-1];
            o_busy <= state_n != IDLE;
            o_done <= done_n;
            o_err <= err_n;
        end
    end
endmodule

// File: tb/tb_rbz_spi_frame_tx.sv
// tb_rbz_spi_frame_tx: checks two transmitter configurations against a frame-level model
module tb_rbz_spi_frame_tx;
    logic clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] start = 2'b00;
    logic [6:0] len [2];
    logic [95:0] data [2];
    logic [1:0] csb, sclk, mosi, busy, done, err;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rbz_spi_frame_tx #(.MAX_BITS(96), .LEN_W(7), .CLK_DIV(2), .GAP_CYCLES(4)) dut0 (
        .i_clk(clk), .i_reset(rst[0]), .i_start(start[0]), .i_len(len[0]), .i_data(data[0]),
        .o_csb(csb[0]), .o_sclk(sclk[0]), .o_mosi(mosi[0]), .o_busy(busy[0]),
        .o_done(done[0]), .o_err(err[0]));

    rbz_spi_frame_tx #(.MAX_BITS(96), .LEN_W(7), .CLK_DIV(1), .GAP_CYCLES(0)) dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_start(start[1]), .i_len(len[1]), .i_data(data[1]),
        .o_csb(csb[1]), .o_sclk(sclk[1]), .o_mosi(mosi[1]), .o_busy(busy[1]),
        .o_done(done[1]), .o_err(err[1]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame on instance k; the model is the spec's timing arithmetic plus an SPI receiver
    task automatic frame(input int k, input int n, input logic [95:0] d, input bit noise);
        int cd = (k == 0) ? 2 : 1;
        int gp = (k == 0) ? 4 : 0;
        int low = cd * (2 * n + 1);
        int first_low = -1, last_low = -1, nlow = 0;
        int first_busy = -1, last_busy = -1, nbusy = 0;
        int ndone = 0, done_at = -1, rises = 0, bad = 0;
        logic prev = 1'b0;
        logic [95:0] got = '0;
        logic [95:0] one = 96'd1;
        logic [95:0] mask;
        mask = (one << n) - 96'd1;
        @(negedge clk);
        data[k] = d;
        len[k] = 7'(n);
        start[k] = 1'b1;
        for (int c = 1; c <= low + gp + 4; c++) begin
            @(negedge clk);
            if (!csb[k]) begin
                nlow++;
                if (first_low < 0) first_low = c;
                last_low = c;
            end
            if (busy[k]) begin
                nbusy++;
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (done[k]) begin
                ndone++;
                done_at = c;
            end
            if (sclk[k] && !prev) begin
                rises++;
                got = {got[94:0], mosi[k]};
            end
            prev = sclk[k];
            if (csb[k] && (sclk[k] || mosi[k])) bad++;
            start[k] = noise && !csb[k] ? 1'($urandom) : 1'b0;
            if (noise) begin
                data[k] = {$urandom, $urandom, $urandom};
                len[k] = 7'($urandom);
            end
        end
        start[k] = 1'b0;
        chk("csb_first_low", 128'(first_low), 128'(1));
        chk("csb_last_low", 128'(last_low), 128'(low));
        chk("csb_low_count", 128'(nlow), 128'(low));
        chk("sclk_rises", 128'(rises), 128'(n));
        chk("rx_bits", 128'(got), 128'(d & mask));
        chk("busy_first", 128'(first_busy), 128'(1));
        chk("busy_last", 128'(last_busy), 128'(low + gp));
        chk("busy_count", 128'(nbusy), 128'(low + gp));
        chk("done_count", 128'(ndone), 128'(1));
        chk("done_cycle", 128'(done_at), 128'(low + gp + 1));
        chk("idle_quiet", 128'(bad), 128'(0));
    endtask

    task automatic bad_len(input int k, input int n);
        int nerr = 0, err_at = -1, nlow = 0, nbusy = 0;
        @(negedge clk);
        len[k] = 7'(n);
        data[k] = {$urandom, $urandom, $urandom};
        start[k] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start[k] = 1'b0;
            if (err[k]) begin
                nerr++;
                err_at = c;
            end
            if (!csb[k]) nlow++;
            if (busy[k]) nbusy++;
        end
        chk("err_count", 128'(nerr), 128'(1));
        chk("err_cycle", 128'(err_at), 128'(1));
        chk("err_csb_low", 128'(nlow), 128'(0));
        chk("err_busy", 128'(nbusy), 128'(0));
    endtask

    task automatic check_idle(input int k, input string tag);
        chk({tag, "_csb"}, 128'(csb[k]), 128'(1));
        chk({tag, "_sclk"}, 128'(sclk[k]), 128'(0));
        chk({tag, "_mosi"}, 128'(mosi[k]), 128'(0));
        chk({tag, "_busy"}, 128'(busy[k]), 128'(0));
        chk({tag, "_done"}, 128'(done[k]), 128'(0));
        chk({tag, "_err"}, 128'(err[k]), 128'(0));
    endtask

    initial begin
        logic [95:0] a, b;
        logic [31:0] q;
        int ndone, hi_between, rises, extra_done;
        logic prev;
        len[0] = '0; len[1] = '0;
        data[0] = '0; data[1] = '0;
        repeat (3) @(negedge clk);
        rst = 2'b00;
        check_idle(0, "reset0");
        check_idle(1, "reset1");

        frame(0, 8, 96'hA5, 1'b0);
        frame(0, 96, {24{4'hA}}, 1'b0);
        frame(1, 1, 96'h1, 1'b0);
        frame(1, 96, {24{4'h5}}, 1'b0);
        bad_len(0, 0);
        bad_len(0, 97);
        bad_len(1, 127);

        // back-to-back frames with start held high on the zero-gap instance
        a = {$urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom};
        q = '0; ndone = 0; hi_between = 0; rises = 0; prev = 1'b0;
        @(negedge clk);
        data[1] = a; len[1] = 7'd12; start[1] = 1'b1;
        for (int c = 1; c <= 200 && ndone < 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                data[1] = b;
                len[1] = 7'd20;
            end
            if (sclk[1] && !prev) begin
                rises++;
                q = {q[30:0], mosi[1]};
            end
            prev = sclk[1];
            if (done[1]) ndone++;
            if (ndone == 1 && csb[1]) hi_between++;
            if (ndone >= 1 && !csb[1]) start[1] = 1'b0;
        end
        start[1] = 1'b0;
        chk("b2b_done", 128'(ndone), 128'(2));
        chk("b2b_gap", 128'(hi_between), 128'(1));
        chk("b2b_rises", 128'(rises), 128'(32));
        chk("b2b_bits", 128'(q), 128'({a[11:0], b[19:0]}));

        // reset after the third sclk rise aborts the frame without done
        rises = 0; prev = 1'b0; extra_done = 0;
        @(negedge clk);
        data[0] = {$urandom, $urandom, $urandom}; len[0] = 7'd16; start[0] = 1'b1;
        for (int c = 1; c <= 100 && rises < 3; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (sclk[0] && !prev) rises++;
            prev = sclk[0];
        end
        chk("abort_rises", 128'(rises), 128'(3));
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_idle(0, "abort");
        repeat (60) begin
            @(negedge clk);
            if (done[0] || busy[0] || !csb[0]) extra_done++;
        end
        chk("abort_quiet", 128'(extra_done), 128'(0));
        frame(0, 16, {$urandom, $urandom, $urandom}, 1'b0);

        // inputs churn every cycle while busy
        for (int i = 0; i < 6; i++)
            frame(i % 2, int'($urandom_range(1, 96)), {$urandom, $urandom, $urandom}, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
